// File: rtl/bcd_pkg.sv
// Shared constants for the sequential binary-to-BCD converter: FSM encoding,
// digit width, add-3 correction values and a constant clog2 for sizing counters.
package bcd_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd5;
  localparam logic [DIGIT_W-1:0] ADJ_ADD    = 4'd3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  // Bits needed to hold values 0..value-1; never returns less than 1.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets +3 so the
// following left shift carries correctly into the next digit.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_digit,
  output logic [DIGIT_W-1:0] o_digit
);

  assign o_digit = (i_digit >= ADJ_THRESH) ? (i_digit + ADJ_ADD) : i_digit;

endmodule

// File: rtl/bcd_convert_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock,
// with start/busy/done handshake, optional auto-start, saturation and blank mask.
module bcd_convert_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W      = 16,
  parameter int DIGITS     = 5,
  parameter int AUTO_START = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [BIN_W-1:0]          bin_in,
  output logic                      busy,
  output logic                      done,
  output logic [DIGIT_W*DIGITS-1:0] bcd_out,
  output logic [DIGITS-1:0]         blank_mask,
  output logic                      ovf,
  output logic [1:0]                dbg_state
);

  // Handshake: start (or a pending auto request) is taken only in IDLE; busy is
  // high from the launch edge until the FINISH edge, at which done pulses for one
  // cycle and bcd_out/blank_mask/ovf update and then hold until the next done.

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int CAT_W = BCD_W + BIN_W;
  localparam int CNT_W = clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(BIN_W);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  logic [1:0]        r_state;
  logic [BIN_W-1:0]  r_bin_shift;
  logic [BCD_W-1:0]  r_bcd_work;
  logic              r_ovf_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [BIN_W-1:0]  r_last;
  logic              r_pending;
  logic              r_busy;
  logic              r_done;
  logic [BCD_W-1:0]  r_bcd_out;
  logic [DIGITS-1:0] r_blank;
  logic              r_ovf;

  logic [BCD_W-1:0]  w_adj;
  logic [CAT_W-1:0]  w_cat;
  logic              w_top_carry;
  logic              w_launch;
  logic              w_bin_changed;
  logic [BCD_W-1:0]  w_final;
  logic [DIGITS-1:0] w_blank;
  logic              w_zero_run;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
        .i_digit (r_bcd_work[g*DIGIT_W +: DIGIT_W]),
        .o_digit (w_adj[g*DIGIT_W +: DIGIT_W])
      );
    end
  endgenerate

  // A 1 leaving the corrected top digit means the value no longer fits.
  assign w_cat         = {w_adj, r_bin_shift} << 1;
  assign w_top_carry   = w_adj[BCD_W-1];
  assign w_launch      = (r_state == ST_IDLE) && (start || r_pending);
  assign w_bin_changed = (AUTO_START != 0) && (bin_in != r_last);

  always_comb begin
    w_final = r_bcd_work;
    if (r_ovf_acc) begin
      for (int i = 0; i < DIGITS; i++) w_final[i*DIGIT_W +: DIGIT_W] = 4'd9;
    end
  end

  always_comb begin
    w_blank    = '0;
    w_zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_zero_run = w_zero_run && (w_final[i*DIGIT_W +: DIGIT_W] == 4'd0);
      w_blank[i] = w_zero_run;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_bin_shift <= '0;
      r_bcd_work  <= '0;
      r_ovf_acc   <= 1'b0;
      r_cnt       <= '0;
      r_last      <= '0;
      r_pending   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_bcd_out   <= '0;
      r_blank     <= BLANK_RST;
      r_ovf       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_bin_changed) r_last <= bin_in;
      // A launch samples the current bin_in, so a change on that edge is already covered.
      if (w_launch)           r_pending <= 1'b0;
      else if (w_bin_changed) r_pending <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (w_launch) begin
            r_bin_shift <= bin_in;
            r_bcd_work  <= '0;
            r_ovf_acc   <= 1'b0;
            r_cnt       <= CNT_LOAD;
            r_busy      <= 1'b1;
            r_state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_bcd_work  <= w_cat[CAT_W-1:BIN_W];
          r_bin_shift <= w_cat[BIN_W-1:0];
          if (w_top_carry) r_ovf_acc <= 1'b1;
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) r_state <= ST_FINISH;
        end
        ST_FINISH: begin
          r_bcd_out <= w_final;
          r_blank   <= w_blank;
          r_ovf     <= r_ovf_acc;
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign bcd_out    = r_bcd_out;
  assign blank_mask = r_blank;
  assign ovf        = r_ovf;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_bcd_convert_seq.sv
// Bench for bcd_convert_seq: three instances (5-digit explicit start, 4-digit
// explicit start, 5-digit auto-start) checked against a divide-by-10 model.
module tb_bcd_convert_seq;

  localparam int EW = 51;  // {ovf, mask[9:0], bcd[39:0]}

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rst_a_n = 1'b0;
  always #5 clk = ~clk;

  logic        start0 = 1'b0, busy0, done0, ovf0;
  logic [15:0] bin0 = '0;
  logic [19:0] bcd0;
  logic [4:0]  mask0;
  logic [1:0]  st0;

  logic        start4 = 1'b0, busy4, done4, ovf4;
  logic [15:0] bin4 = '0;
  logic [15:0] bcd4;
  logic [3:0]  mask4;
  logic [1:0]  st4;

  logic        starta = 1'b0, busya, donea, ovfa;
  logic [15:0] bina = '0;
  logic [19:0] bcda;
  logic [4:0]  maska;
  logic [1:0]  sta;

  bcd_convert_seq #(.BIN_W(16), .DIGITS(5), .AUTO_START(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .start(start0), .bin_in(bin0), .busy(busy0), .done(done0),
    .bcd_out(bcd0), .blank_mask(mask0), .ovf(ovf0), .dbg_state(st0));

  bcd_convert_seq #(.BIN_W(16), .DIGITS(4), .AUTO_START(0)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .bin_in(bin4), .busy(busy4), .done(done4),
    .bcd_out(bcd4), .blank_mask(mask4), .ovf(ovf4), .dbg_state(st4));

  bcd_convert_seq #(.BIN_W(16), .DIGITS(5), .AUTO_START(1)) u_duta (
    .clk(clk), .reset_n(rst_a_n), .start(starta), .bin_in(bina), .busy(busya), .done(donea),
    .bcd_out(bcda), .blank_mask(maska), .ovf(ovfa), .dbg_state(sta));

  logic [EW-1:0] exp0_q[$];
  logic [EW-1:0] exp4_q[$];
  logic [EW-1:0] expa_q[$];
  int n_checks = 0, n_pass = 0;
  int n_done0 = 0, n_done4 = 0, n_donea = 0;

  task automatic check_val(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [EW-1:0] model(input int unsigned v, input int d);
    logic [39:0] b;
    logic [9:0]  m;
    logic        o;
    int unsigned lim, t, p;
    lim = 1;
    for (int i = 0; i < d; i++) lim = lim * 10;
    b = '0; m = '0; o = 1'b0;
    if (v > lim - 1) begin
      o = 1'b1;
      for (int i = 0; i < d; i++) b[4*i +: 4] = 4'h9;
    end else begin
      t = v;
      for (int i = 0; i < d; i++) begin
        b[4*i +: 4] = 4'(t % 10);
        t = t / 10;
      end
      p = 1;
      for (int i = 1; i < d; i++) begin
        p = p * 10;
        m[i] = (v < p);
      end
    end
    return {o, m, b};
  endfunction

  // Scoreboard: every done pulse pops one expected result per instance.
  always @(negedge clk) begin
    if (done0 === 1'b1) begin
      n_done0++;
      check_val("dut0_done_has_exp", EW'(exp0_q.size() != 0), EW'(1));
      if (exp0_q.size() != 0) check_val("dut0_result", {ovf0, 5'b0, mask0, 20'b0, bcd0}, exp0_q.pop_front());
    end
    if (done4 === 1'b1) begin
      n_done4++;
      check_val("dut4_done_has_exp", EW'(exp4_q.size() != 0), EW'(1));
      if (exp4_q.size() != 0) check_val("dut4_result", {ovf4, 6'b0, mask4, 24'b0, bcd4}, exp4_q.pop_front());
    end
    if (donea === 1'b1) begin
      n_donea++;
      check_val("auto_done_has_exp", EW'(expa_q.size() != 0), EW'(1));
      if (expa_q.size() != 0) check_val("auto_result", {ovfa, 5'b0, maska, 20'b0, bcda}, expa_q.pop_front());
    end
  end

  task automatic conv0(input logic [15:0] v, input string tag);
    int cyc;
    @(negedge clk);
    bin0 = v; start0 = 1'b1;
    exp0_q.push_back(model(v, 5));
    @(posedge clk); #1 start0 = 1'b0;
    check_val({tag, "_busy"}, EW'(busy0), EW'(1));
    cyc = 0;
    while (done0 !== 1'b1 && cyc < 40) begin @(posedge clk); #1; cyc++; end
    check_val({tag, "_latency"}, EW'(cyc), EW'(17));
    @(posedge clk); #1;
    check_val({tag, "_done_pulse"}, EW'({busy0, done0}), EW'(0));
    check_val({tag, "_hold"}, {ovf0, 5'b0, mask0, 20'b0, bcd0}, model(v, 5));
  endtask

  task automatic conv4(input logic [15:0] v, input string tag);
    int cyc;
    @(negedge clk);
    bin4 = v; start4 = 1'b1;
    exp4_q.push_back(model(v, 4));
    @(posedge clk); #1 start4 = 1'b0;
    cyc = 0;
    while (done4 !== 1'b1 && cyc < 40) begin @(posedge clk); #1; cyc++; end
    check_val({tag, "_latency"}, EW'(cyc), EW'(17));
    @(posedge clk); #1;
  endtask

  initial begin
    int cyc, base;
    repeat (2) @(negedge clk);
    check_val("reset_dut0", EW'({busy0, done0, ovf0, mask0, bcd0}), EW'({3'b000, 5'b11110, 20'h0}));
    check_val("reset_dut4", EW'({busy4, done4, ovf4, mask4, bcd4}), EW'({3'b000, 4'b1110, 16'h0}));
    reset_n = 1'b1; rst_a_n = 1'b1;
    repeat (2) @(posedge clk);

    conv0(16'd1234, "v1234");
    conv0(16'd65535, "v65535");
    conv0(16'd0, "v0");
    conv0(16'd9, "v9");
    conv0(16'd10, "v10");
    for (int i = 0; i < 4; i++) conv0(16'($urandom_range(0, 65535)), "rand");

    conv4(16'd12345, "d4_12345");
    conv4(16'd9999, "d4_9999");
    conv4(16'd10000, "d4_10000");
    conv4(16'd7, "d4_7");

    // start re-asserted while busy must be ignored
    base = n_done0;
    @(negedge clk); bin0 = 16'd500; start0 = 1'b1; exp0_q.push_back(model(500, 5));
    @(posedge clk); #1 start0 = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); bin0 = 16'd42; start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    repeat (45) @(posedge clk);
    #1 check_val("busy_start_ignored", EW'(n_done0 - base), EW'(1));

    // auto-start: input changes mid-conversion
    base = n_donea;
    @(negedge clk); bina = 16'd100; expa_q.push_back(model(100, 5));
    cyc = 0;
    while (busya !== 1'b1 && cyc < 5) begin @(posedge clk); #1; cyc++; end
    check_val("auto_launch", EW'(busya), EW'(1));
    repeat (4) @(posedge clk);
    @(negedge clk); bina = 16'd777; expa_q.push_back(model(777, 5));
    cyc = 0;
    while (donea !== 1'b1 && cyc < 40) begin @(posedge clk); #1; cyc++; end
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (donea !== 1'b1 && cyc < 40);
    check_val("auto_second_within_18", EW'(cyc <= 18), EW'(1));
    repeat (40) @(posedge clk);
    #1 check_val("auto_done_count", EW'(n_donea - base), EW'(2));

    // reset mid-conversion
    base = n_done0;
    @(negedge clk); bin0 = 16'd1234; start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk); reset_n = 1'b0;
    #1 check_val("midreset_state", EW'({busy0, done0, ovf0, mask0, bcd0}), EW'({3'b000, 5'b11110, 20'h0}));
    repeat (3) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    repeat (25) @(posedge clk);
    #1 check_val("midreset_no_done", EW'(n_done0 - base), EW'(0));
    conv0(16'd4321, "after_reset");

    repeat (3) @(posedge clk);
    check_val("queues_drained", EW'(exp0_q.size() + exp4_q.size() + expa_q.size()), EW'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bcd_convert_seq.md
Name: bcd_convert_seq

Overview:
- Parametrised sequential binary-to-BCD converter. It replaces the repeated-subtract-by-10 converter that feeds the seven-segment driver (`seg`).
- Uses shift-and-add-3 (double dabble), one input bit per clock. Latency is fixed and independent of the input value.
- Adds a start/busy/done handshake, an optional auto-start on input change, overflow saturation, and a leading-zero blanking mask for the display driver.

Parameters:
- BIN_W, 16, width of binary input (legal 1..32).
- DIGITS, 5, number of BCD output digits (legal 1..10).
- AUTO_START, 1, 1 = conversion requested whenever bin_in differs from the last value sampled; 0 = explicit start only.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request conversion of bin_in; sampled only in IDLE.
- bin_in  in  BIN_W  unsigned binary value.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when new outputs are valid.
- bcd_out  out  4*DIGITS  packed BCD, digit 0 (ones) in bits [3:0].
- blank_mask  out  DIGITS  bit i = 1: digit i is a leading zero (for display blanking).
- ovf  out  1  value exceeded 10^DIGITS-1 in the last conversion.

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE, busy=0, done=0, bcd_out=0, blank_mask = all ones except bit 0, ovf=0, work registers=0, bit counter=0, AUTO last-value register=0, pending=0.
- States: IDLE, SHIFT, FINISH.
- IDLE: on an edge with (start | pending):
  - capture bin_in into the shift register;
  - clear the BCD work register and the overflow accumulator;
  - load counter = BIN_W;
  - busy<=1, clear pending, go to SHIFT.
- SHIFT, each edge:
  - every work digit >=5 gets +3 (4-bit, no carry between digits);
  - then shift {bcd_work, bin_shift} left by 1;
  - if the corrected top digit was >=8 before the shift, set the overflow accumulator (sticky);
  - decrement the counter; on the edge where counter==1, go to FINISH.
- FINISH, single edge:
  - register bcd_out = work value, or all 9s if overflow;
  - ovf = overflow accumulator;
  - blank_mask computed from the new bcd_out;
  - done<=1 for exactly one cycle, busy<=0, go to IDLE.
- Latency: start sampled at edge T → outputs updated and done high after edge T+BIN_W+1.
- Throughput: one conversion per BIN_W+2 cycles.
- blank_mask: bit i (i>=1) = 1 iff digits DIGITS-1..i are all zero. Bit 0 is always 0. With ovf=1 the mask is all zero.
- bcd_out, blank_mask and ovf hold their values between done pulses.
- start while busy: ignored when AUTO_START=0. No queueing.
- AUTO_START=1:
  - every edge, compare bin_in with the last-value register;
  - on mismatch, update the register and set pending (this also applies while busy);
  - pending launches a conversion from IDLE using the current bin_in, so the final outputs always reflect the latest stable input.
  - Explicit start is also honoured.
- start and a pending request in the same IDLE edge: a single conversion is launched.
- Reset mid-conversion: abort immediately to reset values. No done pulse.
- bin_in changes during SHIFT do not disturb the captured value.

Decomposition:
- Shared package bcd_pkg holds:
  - state encoding (IDLE/SHIFT/FINISH);
  - DIGIT_W=4;
  - ADJ_THRESH=5, ADJ_ADD=3;
  - a clog2 function used to size the counter (clog2(BIN_W+1)).
- One natural sub-module, bcd_digit_adj: purely combinational 4-bit conditional add-3, instantiated DIGITS times with a generate loop.

Test Plan (BIN_W=16, DIGITS=5 unless stated):
- AUTO_START=0, bin_in=1234, start pulse at edge T → bcd_out=20'h01234, blank_mask=5'b10000, ovf=0, done high only after edge T+17.
- bin_in=65535 → bcd_out=20'h65535, blank_mask=5'b00000, ovf=0. Then bin_in=0 → bcd_out=0, blank_mask=5'b11110.
- DIGITS=4, bin_in=12345 → bcd_out=16'h9999, ovf=1, blank_mask=4'b0000. Then 9999 → 16'h9999, ovf=0.
- AUTO_START=0, start re-asserted during busy with new bin_in=42 → ignored; result is the original value, single done pulse.
- AUTO_START=1, bin_in 100→777 at cycle 5 of a conversion → first done shows 00100, second done within 18 cycles shows 00777, then no further done pulses.
- reset_n low at cycle 8 of a conversion → busy=0, done never pulses, bcd_out=0, blank_mask=5'b11110. After release, a new start converts normally.
